daq_tx_sequencer: RTL and testbench

DAQ_TX_SEQUENCER -- requirements
Module: daq_tx_sequencer

---
 rtl/daq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/daq_tx_sequencer.sv | 161 ++++++++++++++++
 tb/tb_daq_tx_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ transmit sequencer.
// Holds FSM state encoding, header base code and default sizes.
package daq_pkg;

  localparam int N_SRC_DEF = 4;
  localparam int DW_DEF    = 7;

  localparam logic [6:0] HDR_BASE = 7'h40;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
`ifdef DAQ_TX_HEADER_EN
    HEADER  = 3'd2,
`endif
    ENABLE  = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst (async high), d (async in), q (synchronised out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1 <= 1'b0;
      q   <= 1'b0;
    end else begin
      ff1 <= d;
      q   <= ff1;
    end
  end

endmodule

// File: rtl/daq_tx_sequencer.sv
// Grants N_SRC readback sources turn-by-turn access to one UART,
// skipping masked sources, and muxes the granted source onto it.
// Ports: clk, rst (async high); start/src_mask in, busy/done out;
//   per-source src_en, src_data_ready, src_data, src_complete,
//   src_data_loaded; UART side uart_data_ready, uart_data,
//   uart_data_loaded (async to clk).
// Macro DAQ_TX_HEADER_EN: send a header word 0x40|index before
//   each granted source, handshaken on the synchronised loaded flag.
module daq_tx_sequencer
  import daq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_SRC-1:0]    src_mask,
  output logic                busy,
  output logic                done,
  output logic [N_SRC-1:0]    src_en,
  input  logic [N_SRC-1:0]    src_data_ready,
  input  logic [N_SRC*DW-1:0] src_data,
  input  logic [N_SRC-1:0]    src_complete,
  output logic [N_SRC-1:0]    src_data_loaded,
  output logic                uart_data_ready,
  output logic [DW-1:0]       uart_data,
  input  logic                uart_data_loaded
);

  localparam int CW = $clog2(N_SRC);

  state_t           state, state_n;
  logic [CW-1:0]    cur, cur_n;
  logic [N_SRC-1:0] mask_q, mask_n;
  logic             sel_found;
  logic [CW-1:0]    sel_idx;

`ifdef DAQ_TX_HEADER_EN
  logic loaded_s;
  logic hdr_lo, hdr_lo_n;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_data_loaded),
    .q   (loaded_s)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cur    <= '0;
      mask_q <= '0;
`ifdef DAQ_TX_HEADER_EN
      hdr_lo <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      mask_q <= mask_n;
`ifdef DAQ_TX_HEADER_EN
      hdr_lo <= hdr_lo_n;
`endif
    end
  end

  // Lowest unmasked index at or above cur.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = cur;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (!mask_q[i] && (i >= int'(cur))) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    mask_n  = mask_q;
`ifdef DAQ_TX_HEADER_EN
    hdr_lo_n = hdr_lo;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          mask_n  = src_mask;
          cur_n   = '0;
          state_n = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          cur_n = sel_idx;
`ifdef DAQ_TX_HEADER_EN
          state_n = HEADER;
`else
          state_n = ENABLE;
`endif
        end else begin
          state_n = DONE;
        end
      end
`ifdef DAQ_TX_HEADER_EN
      // Phase 0: ready high until loaded seen; phase 1: wait
      // for loaded to fall before granting the source.
      HEADER: begin
        if (!hdr_lo) begin
          if (loaded_s) hdr_lo_n = 1'b1;
        end else if (!loaded_s) begin
          hdr_lo_n = 1'b0;
          state_n  = ENABLE;
        end
      end
`endif
      ENABLE: begin
        if (src_complete[cur]) state_n = RELEASE;
      end
      RELEASE: begin
        if (!src_complete[cur]) begin
          if (cur == CW'(N_SRC - 1)) begin
            state_n = DONE;
          end else begin
            cur_n   = cur + 1'b1;
            state_n = SELECT;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Routing is purely combinational on registered state/cur, so
  // reset clears every output without waiting for a clock.
  always_comb begin
    busy            = (state != IDLE);
    done            = (state == DONE);
    src_en          = '0;
    src_data_loaded = '0;
    uart_data_ready = 1'b0;
    uart_data       = '0;
    if (state == ENABLE) begin
      src_en[cur]          = 1'b1;
      src_data_loaded[cur] = uart_data_loaded;
      uart_data_ready      = src_data_ready[cur];
      uart_data            = src_data[int'(cur)*DW +: DW];
    end
`ifdef DAQ_TX_HEADER_EN
    if (state == HEADER) begin
      uart_data_ready = !hdr_lo;
      uart_data       = DW'(HDR_BASE) | DW'(cur);
    end
`endif
  end

endmodule

// File: tb/tb_daq_tx_sequencer.sv
// Randomised self-checking bench for daq_tx_sequencer.
// Models sources and UART; expects words in ascending unmasked order.
module tb_daq_tx_sequencer;

  localparam int NS = 4;
  localparam int W  = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NS-1:0] src_mask;
  logic          busy;
  logic          done;
  logic [NS-1:0] src_en;
  logic [NS-1:0] src_data_ready;
  logic [NS*W-1:0] src_data;
  logic [NS-1:0] src_complete;
  logic [NS-1:0] src_data_loaded;
  logic          uart_data_ready;
  logic [W-1:0]  uart_data;
  logic          uart_data_loaded;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  logic [NS-1:0] en_seen;

  daq_tx_sequencer #(.N_SRC(NS), .DW(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .src_mask         (src_mask),
    .busy             (busy),
    .done             (done),
    .src_en           (src_en),
    .src_data_ready   (src_data_ready),
    .src_data         (src_data),
    .src_complete     (src_complete),
    .src_data_loaded  (src_data_loaded),
    .uart_data_ready  (uart_data_ready),
    .uart_data        (uart_data),
    .uart_data_loaded (uart_data_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    en_seen |= src_en;
  end

  task automatic clear_inputs();
    start            = 1'b0;
    src_mask         = '0;
    src_data_ready   = '0;
    src_data         = '0;
    src_complete     = '0;
    uart_data_loaded = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    uart_data_loaded = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, src_en, src_data_loaded, uart_data_ready,
         uart_data} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b en=%b ld=%b rdy=%b data=%h want all 0",
               busy, done, src_en, src_data_loaded, uart_data_ready,
               uart_data);
    if ({busy, done, src_en, src_data_loaded, uart_data_ready,
         uart_data} !== '0) errors++;
    uart_data_loaded = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one DAQ cycle. abort_src >= 0 stops once that source is
  // granted; repulse fires start again at every grant.
  task automatic serve(input logic [NS-1:0] m, input int nw,
                       input int abort_src, input bit repulse);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] d;
    logic [NS-1:0] onehot;
    int k;
    done_cnt = 0;
    en_seen  = '0;
    src_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_mask = NS'($urandom);
    for (int i = 0; i < NS; i++) begin
      if (m[i]) continue;
      onehot = NS'(1 << i);
`ifdef DAQ_TX_HEADER_EN
      k = 0;
      while (!uart_data_ready && k < 50) begin
        @(negedge clk); k++;
      end
      d = 7'(32'h40 + i);
      checks++;
      if (uart_data_ready !== 1'b1 || src_en !== '0) begin
        errors++;
        $display("FAIL hdr_ready src%0d got rdy=%b en=%b want rdy=1 en=0",
                 i, uart_data_ready, src_en);
      end
      exp_q.push_back(d);
      got_q.push_back(uart_data);
      uart_data_loaded = 1'b1;
      k = 0;
      while (uart_data_ready && k < 50) begin
        @(negedge clk); k++;
      end
      checks++;
      if (uart_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL hdr_drop src%0d got rdy=%b want 0", i,
                 uart_data_ready);
      end
      uart_data_loaded = 1'b0;
`endif
      k = 0;
      while (src_en == '0 && k < 50) begin
        @(negedge clk); k++;
      end
      checks++;
      if (src_en !== onehot) begin
        errors++;
        $display("FAIL grant got en=%b want %b", src_en, onehot);
      end
      if (i == abort_src) return;
      if (repulse) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      for (int w = 0; w < nw; w++) begin
        d = W'($urandom);
        src_data = (NS*W)'($urandom);
        src_data[i*W +: W] = d;
        src_data_ready = NS'($urandom);
        src_data_ready[i] = 1'b1;
        #1;
        checks++;
        if (uart_data_ready !== 1'b1 || uart_data !== d) begin
          errors++;
          $display("FAIL word src%0d got rdy=%b data=%h want rdy=1 data=%h",
                   i, uart_data_ready, uart_data, d);
        end
        exp_q.push_back(d);
        got_q.push_back(uart_data);
        uart_data_loaded = 1'b1;
        #1;
        checks++;
        if (src_data_loaded !== onehot) begin
          errors++;
          $display("FAIL loaded_route got %b want %b",
                   src_data_loaded, onehot);
        end
        @(negedge clk);
        src_data_ready[i] = 1'b0;
        #1;
        checks++;
        if (uart_data_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_drop src%0d got %b want 0", i,
                   uart_data_ready);
        end
        uart_data_loaded = 1'b0;
        @(negedge clk);
      end
      src_complete[i] = 1'b1;
      k = 0;
      while (src_en != '0 && k < 50) begin
        @(negedge clk); k++;
      end
      checks++;
      if (src_en !== '0 || uart_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL release src%0d got en=%b rdy=%b want 0 0", i,
                 src_en, uart_data_ready);
      end
      src_complete[i] = 1'b0;
    end
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk); k++;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b want 1 1", done,
               busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_idle got done=%b busy=%b want 0 0", done,
               busy);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL done_count got %0d want 1", done_cnt);
    end
    checks++;
    if ((en_seen & m) !== '0) begin
      errors++;
      $display("FAIL masked_grant seen=%b mask=%b want no overlap",
               en_seen, m);
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL word_count got %0d want %0d", got_q.size(),
               exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_q[j]) begin
        errors++;
        $display("FAIL stream[%0d] got %h want %h", j, got_q[j],
                 exp_q[j]);
      end
    end
  endtask

  task automatic test_all_sources();
    serve(4'b0000, 3, -1, 1'b0);
  endtask

  task automatic test_mask_1010();
    serve(4'b1010, 2, -1, 1'b0);
  endtask

  task automatic test_all_masked();
    done_cnt = 0;
    src_mask = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || src_en !== '0 ||
        uart_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL masked_c1 got done=%b busy=%b en=%b rdy=%b want 0 1 0 0",
               done, busy, src_en, uart_data_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || src_en !== '0 || uart_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL masked_c2 got done=%b en=%b rdy=%b want 1 0 0",
               done, src_en, uart_data_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL masked_end got done=%b busy=%b cnt=%0d want 0 0 1",
               done, busy, done_cnt);
    end
  endtask

  task automatic test_rst_mid();
    serve(4'b0000, 2, 2, 1'b0);
    src_data_ready[2] = 1'b1;
    uart_data_loaded  = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, src_en, src_data_loaded, uart_data_ready,
         uart_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b done=%b en=%b ld=%b rdy=%b data=%h want all 0",
               busy, done, src_en, src_data_loaded, uart_data_ready,
               uart_data);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    serve(4'b0000, 2, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    serve(4'b0000, 2, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++)
      serve(NS'($urandom), int'($urandom_range(1, 4)), -1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_all_sources();
    test_mask_1010();
    test_all_masked();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
